// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load extraction, register-file write port and HI/LO.
// Optional retire counter output enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_low,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_we,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
`ifdef MEM_WB_RETIRE_CNT_EN
    output logic [31:0]       retire_cnt,
`endif
    output logic              wb_misalign
);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_RSV6 = 3'd6,
        LD_RSV7 = 3'd7
    } ld_op_e;

    logic              r_valid;
    logic [REG_AW-1:0] r_wd;
    logic              r_wreg;
    logic [DATA_W-1:0] r_wdata;
    ld_op_e            r_load_op;
    logic [1:0]        r_addr_low;
    logic [DATA_W-1:0] r_load_data;
    logic              r_whilo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi_arch;
    logic [DATA_W-1:0] r_lo_arch;

    logic              w_capture;
    logic              w_bubble;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_result;
    logic              w_misalign_raw;
    logic              w_misalign;

    // Flush wins over any stall; a stalled MEM with a free WB inserts a bubble.
    assign w_capture = !flush && !stall_mem;
    assign w_bubble  = flush || (stall_mem && !stall_wb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_wdata     <= '0;
            r_load_op   <= LD_NONE;
            r_addr_low  <= '0;
            r_load_data <= '0;
            r_whilo     <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_wdata     <= '0;
            r_load_op   <= LD_NONE;
            r_addr_low  <= '0;
            r_load_data <= '0;
            r_whilo     <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_wd        <= mem_wd;
            r_wreg      <= mem_wreg;
            r_wdata     <= mem_wdata;
            r_load_op   <= ld_op_e'(mem_load_op);
            r_addr_low  <= mem_addr_low;
            r_load_data <= mem_load_data;
            r_whilo     <= mem_whilo;
            r_hi        <= mem_hi;
            r_lo        <= mem_lo;
        end
    end

    // The instruction in WB commits HI/LO even on the edge that flushes the latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi_arch <= '0;
            r_lo_arch <= '0;
        end else if (r_valid && r_whilo) begin
            r_hi_arch <= r_hi;
            r_lo_arch <= r_lo;
        end
    end

    always_comb begin
        w_byte = '0;
        case (r_addr_low)
            2'd0:    w_byte = r_load_data[31:24];
            2'd1:    w_byte = r_load_data[23:16];
            2'd2:    w_byte = r_load_data[15:8];
            default: w_byte = r_load_data[7:0];
        endcase
        w_half = r_addr_low[1] ? r_load_data[15:0] : r_load_data[31:16];
    end

    always_comb begin
        w_ld_result    = r_wdata;
        w_misalign_raw = 1'b0;
        case (r_load_op)
            LD_LB:  w_ld_result = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_LBU: w_ld_result = {{(DATA_W-8){1'b0}}, w_byte};
            LD_LH: begin
                w_ld_result    = {{(DATA_W-16){w_half[15]}}, w_half};
                w_misalign_raw = r_addr_low[0];
            end
            LD_LHU: begin
                w_ld_result    = {{(DATA_W-16){1'b0}}, w_half};
                w_misalign_raw = r_addr_low[0];
            end
            LD_LW: begin
                w_ld_result    = r_load_data;
                w_misalign_raw = (r_addr_low != 2'b00);
            end
            default: w_ld_result = r_wdata;
        endcase
    end

    assign w_misalign  = r_valid && w_misalign_raw;
    assign wb_misalign = w_misalign;
    assign wb_waddr    = r_wd;
    assign wb_wdata    = w_misalign ? '0 : w_ld_result;
    assign wb_we       = r_valid && r_wreg && (r_wd != '0) && !w_misalign;
    assign wb_whilo    = r_valid && r_whilo;
    assign wb_hi       = r_hi;
    assign wb_lo       = r_lo;
    assign hi_o        = r_hi_arch;
    assign lo_o        = r_lo_arch;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (w_capture) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, loads, misalignment, stalls, flush and HI/LO.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_low;
    logic [31:0] mem_load_data;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        wb_misalign;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int unsigned n_vec;
    int unsigned n_err;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_mem    (stall_mem),
        .stall_wb     (stall_wb),
        .flush        (flush),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_load_op  (mem_load_op),
        .mem_addr_low (mem_addr_low),
        .mem_load_data(mem_load_data),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .wb_we        (wb_we),
        .wb_whilo     (wb_whilo),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
`ifdef MEM_WB_RETIRE_CNT_EN
        .retire_cnt   (retire_cnt),
`endif
        .wb_misalign  (wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [2:0] op, input logic [1:0] al, input logic [31:0] ld,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        mem_wd        = wd;
        mem_wreg      = wreg;
        mem_wdata     = wdata;
        mem_load_op   = op;
        mem_addr_low  = al;
        mem_load_data = ld;
        mem_whilo     = whilo;
        mem_hi        = hi;
        mem_lo        = lo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load vectors on raw word 0x80F17F02: op, addr_low, expected write-back data.
    logic [2:0]  ld_op  [9] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd6};
    logic [1:0]  ld_al  [9] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
    logic [31:0] ld_exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80F1,
                                32'h00007F02, 32'h80F17F02, 32'h00000002, 32'hFFFFFFF1,
                                32'h0000DEAD};

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush     = 1'b0;
        drive(5'd9, 1'b1, 32'hCAFEF00D, 3'd0, 2'd0, 32'h0, 1'b1, 32'h11111111, 32'h22222222);
        #22;
        check("reset_we", {31'b0, wb_we}, 32'h0);
        check("reset_wdata", wb_wdata, 32'h0);
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_whilo", {31'b0, wb_whilo}, 32'h0);
        rst = 1'b1;

        drive(5'd3, 1'b1, 32'h12345678, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("alu_waddr", {27'b0, wb_waddr}, 32'd3);
        check("alu_wdata", wb_wdata, 32'h12345678);
        check("alu_we", {31'b0, wb_we}, 32'h1);

        for (int i = 0; i < 9; i++) begin
            drive(5'd5, 1'b1, 32'h0000DEAD, ld_op[i], ld_al[i], 32'h80F17F02, 1'b0, 32'h0, 32'h0);
            step();
            check($sformatf("load%0d_wdata", i), wb_wdata, ld_exp[i]);
            check($sformatf("load%0d_we", i), {31'b0, wb_we}, 32'h1);
        end

        drive(5'd5, 1'b1, 32'h0000DEAD, 3'd5, 2'd2, 32'h80F17F02, 1'b0, 32'h0, 32'h0);
        step();
        check("lw_mis_flag", {31'b0, wb_misalign}, 32'h1);
        check("lw_mis_we", {31'b0, wb_we}, 32'h0);
        check("lw_mis_wdata", wb_wdata, 32'h0);
        drive(5'd5, 1'b1, 32'h0000DEAD, 3'd3, 2'd1, 32'h80F17F02, 1'b0, 32'h0, 32'h0);
        step();
        check("lh_mis_flag", {31'b0, wb_misalign}, 32'h1);
        check("lh_mis_we", {31'b0, wb_we}, 32'h0);
        check("lh_mis_wdata", wb_wdata, 32'h0);

        drive(5'd0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b1, 32'hAAAA0000, 32'h0000BBBB);
        step();
        check("hilo_fwd_valid", {31'b0, wb_whilo}, 32'h1);
        check("hilo_fwd_hi", wb_hi, 32'hAAAA0000);
        check("hilo_fwd_lo", wb_lo, 32'h0000BBBB);
        check("hilo_no_bypass", hi_o, 32'h0);
        drive(5'd0, 1'b1, 32'h55555555, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("hilo_commit_hi", hi_o, 32'hAAAA0000);
        check("hilo_commit_lo", lo_o, 32'h0000BBBB);
        check("r0_we", {31'b0, wb_we}, 32'h0);

        drive(5'd7, 1'b1, 32'h00000011, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
        drive(5'd8, 1'b1, 32'hBADBAD00, 3'd0, 2'd0, 32'h0, 1'b1, 32'h1, 32'h2);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold%0d_waddr", c), {27'b0, wb_waddr}, 32'd7);
            check($sformatf("hold%0d_wdata", c), wb_wdata, 32'h00000011);
            check($sformatf("hold%0d_we", c), {31'b0, wb_we}, 32'h1);
        end
        stall_wb = 1'b0;
        step();
        check("bubble_we", {31'b0, wb_we}, 32'h0);
        check("bubble_waddr", {27'b0, wb_waddr}, 32'd0);

        stall_mem = 1'b0;
        drive(5'd6, 1'b1, 32'h00000066, 3'd0, 2'd0, 32'h0, 1'b1, 32'h00001234, 32'h00005678);
        step();
        flush     = 1'b1;
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
        step();
        check("flush_stall_we", {31'b0, wb_we}, 32'h0);
        check("flush_stall_wdata", wb_wdata, 32'h0);
        check("flush_stall_whilo", {31'b0, wb_whilo}, 32'h0);
        check("flush_commit_hi", hi_o, 32'h00001234);
        check("flush_commit_lo", lo_o, 32'h00005678);

        flush     = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        drive(5'd4, 1'b1, 32'h00000099, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_we", {31'b0, wb_we}, 32'h0);
        check("async_rst_wdata", wb_wdata, 32'h0);
        check("async_rst_hi", hi_o, 32'h0);
        check("async_rst_lo", lo_o, 32'h0);
        @(negedge clk);
        rst       = 1'b1;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        check("post_rst_we", {31'b0, wb_we}, 32'h0);

`ifdef MEM_WB_RETIRE_CNT_EN
        check("retire_reset", retire_cnt, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(5'(k + 1), 1'b1, 32'(k), 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
            step();
        end
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush     = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        check("retire_count", retire_cnt, 32'd5);
        force dut.r_retire_cnt = 32'hFFFFFFFE;
        #1;
        release dut.r_retire_cnt;
        step();
        check("retire_max", retire_cnt, 32'hFFFFFFFF);
        step();
        check("retire_wrap", retire_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
